clk_rate_ctrl: RTL and testbench

CLK_RATE_CTRL -- requirements
Module: clk_rate_ctrl

---
 rtl/clk_rate_ctrl.sv | 95 +++++++++
 tb/tb_clk_rate_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_ctrl.sv
// Selectable-rate square-wave generator (1 Hz .. 1 kHz from a free-running decade chain)
// with glitch-free rate switching: a switch requested while clk_out is high waits for the low phase.
module clk_rate_ctrl #(
    parameter logic [31:0] TICK_DIV = 32'd25000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       en,
    output logic       clk_out,
    output logic       rise_tick,
    output logic [1:0] active_sel,
    output logic       busy
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] WAIT_LOW = 1'b1;

    logic [31:0] pc;
    logic [3:0]  d1, d2, d3;
    logic        t0, t1, t2, t3, ts;
    logic [0:0]  state;

    assign t0 = (pc == TICK_DIV - 32'd1);
    assign t1 = t0 && (d1 == 4'd9);
    assign t2 = t1 && (d2 == 4'd9);
    assign t3 = t2 && (d3 == 4'd9);

    always_comb begin
        ts = t3;
        case (active_sel)
            2'd0:    ts = t3;
            2'd1:    ts = t2;
            2'd2:    ts = t1;
            default: ts = t0;
        endcase
    end

    // Prescaler and decade chain run free so every rate stays phase-aligned to the others.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            pc <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            pc <= t0 ? 32'd0 : pc + 32'd1;
            if (t0) d1 <= (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
            if (t1) d2 <= (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            if (t2) d3 <= (d3 == 4'd9) ? 4'd0 : d3 + 4'd1;
        end
    end

    // A high phase always finishes even with en low; only new rises are gated.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
        end else begin
            rise_tick <= ts && en && !clk_out;
            if (ts && (en || clk_out))
                clk_out <= !clk_out;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state      <= RUN;
            active_sel <= 2'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (sel != active_sel) begin
                        if (!clk_out) begin
                            active_sel <= sel;
                        end else begin
                            state <= WAIT_LOW;
                            busy  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Commit whatever sel is at the first low cycle; intermediate requests are ignored.
                    if (!clk_out) begin
                        active_sel <= sel;
                        state      <= RUN;
                        busy       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Bench for clk_rate_ctrl at TICK_DIV=2: a tick-arithmetic reference model compared every
// cycle, plus directed scenarios with literal expectations on periods, phases and switching.
module tb_clk_rate_ctrl;

    localparam int TD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'd3;
    logic       en  = 1'b1;
    logic       clk_out, rise_tick, busy;
    logic [1:0] active_sel;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    clk_rate_ctrl #(.TICK_DIV(32'd2)) dut (
        .clk_50MHz (clk),
        .rst       (rst),
        .sel       (sel),
        .en        (en),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .active_sel(active_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: ticks derived from cycles elapsed since reset, not from counters.
    int   m_k = 0;
    bit   m_clk = 0, m_rise = 0, m_wait = 0, m_valid = 0;
    bit [1:0] m_act = 0;

    function automatic int rate_period(input bit [1:0] r);
        return TD * (10 ** (3 - int'(r)));
    endfunction

    always @(posedge clk) begin
        bit ts, nclk;
        if (rst) begin
            m_k = 0; m_clk = 0; m_rise = 0; m_act = 0; m_wait = 0; m_valid = 1;
        end else begin
            ts   = ((m_k + 1) % rate_period(m_act)) == 0;
            nclk = m_clk;
            if (ts && (en || m_clk)) nclk = !m_clk;
            if (!m_wait) begin
                if (sel != m_act) begin
                    if (!m_clk) m_act = sel;
                    else        m_wait = 1;
                end
            end else if (!m_clk) begin
                m_act  = sel;
                m_wait = 0;
            end
            m_rise = nclk && !m_clk;
            m_clk  = nclk;
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_clk_out", 32'(clk_out), 32'(m_clk));
            chk("model_rise_tick", 32'(rise_tick), 32'(m_rise));
            chk("model_active_sel", 32'(active_sel), 32'(m_act));
            chk("model_busy", 32'(busy), 32'(m_wait));
        end
    end

    task automatic wait_rise(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rise_tick === 1'b1) begin t = cyc; break; end
        end
        if (t < 0) chk("timeout_rise", 32'd0, 32'd1);
    endtask

    task automatic wait_fall(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (clk_out === 1'b0) begin t = cyc; break; end
        end
        if (t < 0) chk("timeout_fall", 32'd0, 32'd1);
    endtask

    initial begin
        int ta, tb, tf, n_rise, n_high, busy_rises, act_changes, commit_seen;
        logic pb;
        logic [1:0] pa;

        // Reset with sel=3 requested
        repeat (2) @(negedge clk);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active", 32'(active_sel), 32'd0);
        chk("rst_rise", 32'(rise_tick), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("commit_after_rst", 32'(active_sel), 32'd3);
        chk("commit_after_rst_busy", 32'(busy), 32'd0);

        // 1 kHz: period 4, 2 high
        wait_rise(20, ta);
        wait_rise(20, tb);
        chk("period_1k", 32'(tb - ta), 32'd4);
        wait_fall(20, tf);
        chk("high_1k", 32'(tf - tb), 32'd2);
        n_rise = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rise_tick) n_rise++;
        end
        chk("rises_in_40", 32'(n_rise), 32'd10);

        // 1 Hz: period 4000, half 2000
        sel = 2'd0;
        wait_rise(5000, ta);
        wait_rise(5000, tb);
        chk("period_1hz", 32'(tb - ta), 32'd4000);
        wait_fall(5000, tf);
        chk("high_1hz", 32'(tf - tb), 32'd2000);

        // Switch 0 -> 3 while high: wait for the t3-driven fall
        wait_rise(5000, ta);
        repeat (10) @(negedge clk);
        sel = 2'd3;
        @(negedge clk);
        chk("busy_set", 32'(busy), 32'd1);
        n_high = 0;
        tf = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (clk_out === 1'b0) begin tf = cyc; break; end
            if (busy !== 1'b1) n_high++;
        end
        chk("busy_gap_in_wait", 32'(n_high), 32'd0);
        chk("high_before_switch", 32'(tf - ta), 32'd2000);
        chk("busy_at_fall", 32'(busy), 32'd1);
        chk("active_at_fall", 32'(active_sel), 32'd0);
        @(negedge clk);
        chk("busy_after_commit", 32'(busy), 32'd0);
        chk("active_after_commit", 32'(active_sel), 32'd3);

        // Back to 1 Hz, then toggle sel 3->2->1 during the wait
        sel = 2'd0;
        wait_rise(5000, ta);
        sel = 2'd3;
        busy_rises = 0; act_changes = 0; commit_seen = 0;
        pb = busy; pa = active_sel;
        for (int i = 0; i < 4500; i++) begin
            @(negedge clk);
            if (i == 100) sel = 2'd2;
            if (i == 200) sel = 2'd1;
            if (busy && !pb) busy_rises++;
            if (active_sel != pa) act_changes++;
            if (!busy && pb) commit_seen = 1;
            pb = busy; pa = active_sel;
            if (commit_seen && i > 210) break;
        end
        chk("single_commit_seen", 32'(commit_seen), 32'd1);
        chk("busy_intervals", 32'(busy_rises), 32'd1);
        chk("active_changes", 32'(act_changes), 32'd1);
        chk("final_active", 32'(active_sel), 32'd1);

        // en dropped mid high phase at 100 Hz
        sel = 2'd2;
        wait_rise(500, ta);
        repeat (5) @(negedge clk);
        en = 1'b0;
        wait_fall(100, tf);
        chk("high_100hz_en_off", 32'(tf - ta), 32'd20);
        n_rise = 0; n_high = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rise_tick) n_rise++;
            if (clk_out)   n_high++;
        end
        chk("en_off_rises", 32'(n_rise), 32'd0);
        chk("en_off_highs", 32'(n_high), 32'd0);
        en = 1'b1;
        wait_rise(50, ta);

        // Reset during WAIT_LOW discards the pending switch
        sel = 2'd3;
        @(negedge clk);
        chk("wait_low_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_clk_out", 32'(clk_out), 32'd0);
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_active", 32'(active_sel), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_active", 32'(active_sel), 32'd3);
        chk("post_rst_clk_low", 32'(clk_out), 32'd0);
        @(negedge clk);
        chk("post_rst_first_rise", 32'(rise_tick), 32'd1);
        chk("post_rst_clk_high", 32'(clk_out), 32'd1);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
